// File: rtl/axis_video_tx.sv
// AXI-Stream video transmitter: turns a valid/ready pixel feed into one framed
// stream per start command (tuser = start of frame, tlast = end of line).
module axis_video_tx #(
  parameter int AXIS_DATA_WIDTH = 24,
  parameter int LINE_W          = 3840,
  parameter int FRAME_H         = 2160
) (
  input  logic                         aclk,
  input  logic                         arst,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  input  logic                         pix_valid,
  output logic                         pix_ready,
  input  logic [AXIS_DATA_WIDTH-1:0]   pix_data,
  output logic                         axis_tvalid,
  input  logic                         axis_tready,
  output logic                         axis_tid,
  output logic [AXIS_DATA_WIDTH-1:0]   axis_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0] axis_tstrb,
  output logic [AXIS_DATA_WIDTH/8-1:0] axis_tkeep,
  output logic                         axis_tlast,
  output logic                         axis_tuser,
  output logic                         axis_tdest
);
  localparam int AXIS_STRB_WIDTH = AXIS_DATA_WIDTH / 8;
  localparam int TOTAL = LINE_W * FRAME_H;
  localparam int XW = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam int YW = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;
  localparam int AW = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  typedef struct packed {
    logic                       eof;
    logic                       tuser;
    logic                       tlast;
    logic [AXIS_DATA_WIDTH-1:0] data;
  } beat_t;

  state_t          state, state_nxt;
  logic [XW-1:0]   x_in;
  logic [YW-1:0]   y_in;
  logic [AW-1:0]   acc_cnt;
  logic [1:0]      buf_cnt;
  beat_t           slot_p0, slot_p1, beat_in;
  logic            push, pop, x_last, y_last;

  assign x_last    = (x_in == XW'(LINE_W - 1));
  assign y_last    = (y_in == YW'(FRAME_H - 1));
  assign pix_ready = (state == STREAM) && (buf_cnt != 2'd2) && (acc_cnt < AW'(TOTAL));
  assign push      = pix_valid & pix_ready;
  assign pop       = axis_tvalid & axis_tready;
  // eof rides with the pixel so the frame end is known at the head without a beat counter
  assign beat_in   = {x_last & y_last, (x_in == '0) && (y_in == '0), x_last, pix_data};

  always_ff @(posedge aclk) begin
    if (arst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = STREAM;
      STREAM:  if (pop && slot_p0.eof) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- intake stage: raster position of the next accepted pixel
  always_ff @(posedge aclk) begin
    if (arst) begin
      x_in    <= '0;
      y_in    <= '0;
      acc_cnt <= '0;
    end else if (state == IDLE && start) begin
      x_in    <= '0;
      y_in    <= '0;
      acc_cnt <= '0;
    end else if (push) begin
      acc_cnt <= acc_cnt + 1'b1;
      if (x_last) begin
        x_in <= '0;
        y_in <= y_last ? '0 : y_in + 1'b1;
      end else begin
        x_in <= x_in + 1'b1;
      end
    end
  end

  // ---- output stage: two-slot buffer, slot_p0 is the head seen on the bus
  always_ff @(posedge aclk) begin
    if (arst) begin
      buf_cnt <= 2'd0;
      slot_p0 <= '0;
      slot_p1 <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (buf_cnt == 2'd0) slot_p0 <= beat_in;
          else                 slot_p1 <= beat_in;
          buf_cnt <= buf_cnt + 2'd1;
        end
        2'b01: begin
          slot_p0 <= slot_p1;
          buf_cnt <= buf_cnt - 2'd1;
        end
        // push with pop only happens holding one entry: the new beat replaces the head
        2'b11:   slot_p0 <= beat_in;
        default: ;
      endcase
    end
  end

  assign axis_tvalid = (buf_cnt != 2'd0);
  assign axis_tdata  = slot_p0.data;
  assign axis_tlast  = slot_p0.tlast;
  assign axis_tuser  = slot_p0.tuser;
  assign axis_tid    = 1'b0;
  assign axis_tdest  = 1'b0;
  assign axis_tstrb  = {AXIS_STRB_WIDTH{1'b1}};
  assign axis_tkeep  = {AXIS_STRB_WIDTH{1'b1}};
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);

endmodule

// File: tb/tb_axis_video_tx.sv
// Bench for axis_video_tx: a 4x2 instance for directed frames and a 3x3 instance
// for randomized traffic, both checked every cycle against a queue-based model.
`timescale 1ns/1ps
module tb_axis_video_tx;
  localparam int DW = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          arst;
  logic          start [2];
  logic          pix_valid [2];
  logic          axis_tready [2];
  logic [DW-1:0] pix_data [2];

  logic          busy0, done0, pix_ready0, tvalid0, tid0, tlast0, tuser0, tdest0;
  logic [DW-1:0] tdata0;
  logic [2:0]    tstrb0, tkeep0;
  logic          busy1, done1, pix_ready1, tvalid1, tid1, tlast1, tuser1, tdest1;
  logic [DW-1:0] tdata1;
  logic [2:0]    tstrb1, tkeep1;

  axis_video_tx #(.AXIS_DATA_WIDTH(DW), .LINE_W(4), .FRAME_H(2)) u_dut0 (
    .aclk(clk), .arst(arst), .start(start[0]), .busy(busy0), .done(done0),
    .pix_valid(pix_valid[0]), .pix_ready(pix_ready0), .pix_data(pix_data[0]),
    .axis_tvalid(tvalid0), .axis_tready(axis_tready[0]), .axis_tid(tid0),
    .axis_tdata(tdata0), .axis_tstrb(tstrb0), .axis_tkeep(tkeep0),
    .axis_tlast(tlast0), .axis_tuser(tuser0), .axis_tdest(tdest0));

  axis_video_tx #(.AXIS_DATA_WIDTH(DW), .LINE_W(3), .FRAME_H(3)) u_dut1 (
    .aclk(clk), .arst(arst), .start(start[1]), .busy(busy1), .done(done1),
    .pix_valid(pix_valid[1]), .pix_ready(pix_ready1), .pix_data(pix_data[1]),
    .axis_tvalid(tvalid1), .axis_tready(axis_tready[1]), .axis_tid(tid1),
    .axis_tdata(tdata1), .axis_tstrb(tstrb1), .axis_tkeep(tkeep1),
    .axis_tlast(tlast1), .axis_tuser(tuser1), .axis_tdest(tdest1));

  int n_cmp = 0;
  int n_fail = 0;

  // Model: frame phase (0 idle, 1 streaming, 2 done), pixels accepted/sent this frame,
  // and the queue of pixels accepted but not yet sent.
  int            ms [2];
  int            acc [2];
  int            xfer [2];
  int            frames [2];
  int            cnt_tl [2];
  int            cnt_tu [2];
  logic [DW-1:0] q [2][$];
  bit            src_acc [2];
  int            data_ctr [2];
  bit            rnd_data = 1'b0;
  bit            m_init = 1'b0;
  bit            saw_full = 1'b0;
  int            cyc = 0;

  int lg_data [$];
  bit lg_tu [$];
  bit lg_tl [$];
  int lg_cyc [$];
  int dn_cyc [$];

  function automatic int lw(int k);
    return (k == 0) ? 4 : 3;
  endfunction

  function automatic int fh(int k);
    return (k == 0) ? 2 : 3;
  endfunction

  task automatic chk(int k, string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (dut%0d) t=%0t: got 0x%0h, want 0x%0h", nm, k, $time, act, exp);
    end
  endtask

  function automatic void reset_model(int k);
    ms[k] = 0; acc[k] = 0; xfer[k] = 0;
    cnt_tl[k] = 0; cnt_tu[k] = 0;
    q[k].delete();
    src_acc[k] = 1'b0;
  endfunction

  // Compare process: check outputs against the model, then advance the model by one edge.
  always @(negedge clk) begin
    logic          o_rdy [2], o_vld [2], o_busy [2], o_done [2];
    logic          o_tid [2], o_tdest [2], o_tl [2], o_tu [2];
    logic [DW-1:0] o_dat [2];
    logic [2:0]    o_strb [2], o_keep [2];
    int            occ, tot;
    bit            e_rdy, e_vld, a_now, x_now;

    cyc++;
    o_rdy[0] = pix_ready0; o_vld[0] = tvalid0; o_busy[0] = busy0; o_done[0] = done0;
    o_tid[0] = tid0; o_tdest[0] = tdest0; o_tl[0] = tlast0; o_tu[0] = tuser0;
    o_dat[0] = tdata0; o_strb[0] = tstrb0; o_keep[0] = tkeep0;
    o_rdy[1] = pix_ready1; o_vld[1] = tvalid1; o_busy[1] = busy1; o_done[1] = done1;
    o_tid[1] = tid1; o_tdest[1] = tdest1; o_tl[1] = tlast1; o_tu[1] = tuser1;
    o_dat[1] = tdata1; o_strb[1] = tstrb1; o_keep[1] = tkeep1;

    if (!m_init) begin
      if (arst === 1'b1) begin
        m_init = 1'b1;
        reset_model(0);
        reset_model(1);
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        tot   = lw(k) * fh(k);
        occ   = q[k].size();
        e_rdy = (ms[k] == 1) && (occ < 2) && (acc[k] < tot);
        e_vld = (occ > 0);
        chk(k, "pix_ready", o_rdy[k], e_rdy);
        chk(k, "tvalid", o_vld[k], e_vld);
        chk(k, "busy", o_busy[k], ms[k] != 0);
        chk(k, "done", o_done[k], ms[k] == 2);
        chk(k, "tid", o_tid[k], 0);
        chk(k, "tdest", o_tdest[k], 0);
        chk(k, "tstrb", o_strb[k], 3'b111);
        chk(k, "tkeep", o_keep[k], 3'b111);
        if (e_vld) begin
          chk(k, "tdata", o_dat[k], q[k][0]);
          chk(k, "tuser", o_tu[k], xfer[k] == 0);
          chk(k, "tlast", o_tl[k], (xfer[k] % lw(k)) == lw(k) - 1);
        end
        if (k == 0 && occ == 2 && o_rdy[0] === 1'b0) saw_full = 1'b1;
        if (k == 0 && o_vld[0] === 1'b1 && axis_tready[0]) begin
          lg_data.push_back(int'(o_dat[0]));
          lg_tu.push_back(o_tu[0]);
          lg_tl.push_back(o_tl[0]);
          lg_cyc.push_back(cyc);
        end
        if (k == 0 && o_done[0] === 1'b1) dn_cyc.push_back(cyc);

        if (arst) begin
          reset_model(k);
        end else begin
          a_now = pix_valid[k] && e_rdy;
          x_now = e_vld && axis_tready[k];
          src_acc[k] = a_now;
          if (x_now) begin
            void'(q[k].pop_front());
            xfer[k]++;
            cnt_tl[k] += int'(o_tl[k]);
            cnt_tu[k] += int'(o_tu[k]);
          end
          if (a_now) begin
            q[k].push_back(pix_data[k]);
            acc[k]++;
          end
          case (ms[k])
            0: if (start[k]) begin
              ms[k] = 1; acc[k] = 0; xfer[k] = 0; cnt_tl[k] = 0; cnt_tu[k] = 0;
            end
            1: if (x_now && xfer[k] == tot) ms[k] = 2;
            default: begin
              chk(k, "tlast_per_frame", cnt_tl[k], fh(k));
              chk(k, "tuser_per_frame", cnt_tu[k], 1);
              frames[k]++;
              ms[k] = 0;
            end
          endcase
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (src_acc[k]) begin
        data_ctr[k]++;
        pix_data[k] = rnd_data ? DW'($urandom) : DW'(data_ctr[k]);
      end
    end
  endtask

  task automatic clear_logs();
    lg_data.delete(); lg_tu.delete(); lg_tl.delete(); lg_cyc.delete(); dn_cyc.delete();
  endtask

  task automatic restart_src(int v);
    data_ctr[0] = v;
    pix_data[0] = DW'(v);
  endtask

  task automatic run_frames(int ndone, int rmode);
    int i = 0;
    while (dn_cyc.size() < ndone && i < 200) begin
      axis_tready[0] = (rmode == 0) ? 1'b1 : ((i % 4 == 0) || (i % 4 == 3));
      tick();
      i++;
    end
    axis_tready[0] = 1'b1;
    chk(0, "done_pulses", dn_cyc.size(), ndone);
  endtask

  task automatic check_frame(int n, int first);
    chk(0, "beat_count", lg_data.size(), n);
    for (int i = 0; i < lg_data.size() && i < n; i++) begin
      chk(0, "beat_data", lg_data[i], first + i);
      chk(0, "beat_tuser", lg_tu[i], (i % 8) == 0);
      chk(0, "beat_tlast", lg_tl[i], (i % 4) == 3);
    end
  endtask

  initial begin
    #800us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    arst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0; pix_valid[k] = 1'b0; axis_tready[k] = 1'b1;
      data_ctr[k] = 1; pix_data[k] = DW'(1);
    end
    repeat (3) tick();
    arst = 1'b0;
    chk(0, "rst_tvalid", tvalid0, 0);
    chk(0, "rst_tdata", tdata0, 0);
    chk(0, "rst_tlast", tlast0, 0);
    chk(0, "rst_tuser", tuser0, 0);
    chk(0, "rst_pix_ready", pix_ready0, 0);
    chk(0, "rst_busy", busy0, 0);
    chk(0, "rst_done", done0, 0);

    // Continuous stream, sink always ready
    clear_logs();
    start[0] = 1'b1; pix_valid[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    run_frames(1, 0);
    pix_valid[0] = 1'b0;
    check_frame(8, 1);
    for (int j = 1; j < lg_cyc.size(); j++) chk(0, "beat_spacing", lg_cyc[j] - lg_cyc[j-1], 1);
    if (lg_cyc.size() == 8 && dn_cyc.size() == 1) chk(0, "done_after_last", dn_cyc[0], lg_cyc[7] + 1);
    chk(0, "busy_after_frame", busy0, 0);

    // Sink stalls with a 1,0,0,1 ready pattern
    clear_logs(); restart_src(1); saw_full = 1'b0;
    start[0] = 1'b1; pix_valid[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    run_frames(1, 1);
    pix_valid[0] = 1'b0;
    check_frame(8, 1);
    chk(0, "full_backpressure_seen", saw_full, 1);

    // Pixels offered before start, and a second start mid-frame
    clear_logs(); restart_src(1);
    pix_valid[0] = 1'b1;
    repeat (4) begin
      tick();
      chk(0, "idle_pix_ready", pix_ready0, 0);
      chk(0, "idle_tvalid", tvalid0, 0);
    end
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    repeat (4) tick();
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    run_frames(1, 0);
    repeat (4) tick();
    pix_valid[0] = 1'b0;
    check_frame(8, 1);

    // Reset in mid-frame with two beats buffered
    clear_logs(); restart_src(1);
    pix_valid[0] = 1'b1;
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    i = 0;
    while (lg_data.size() < 3 && i < 50) begin tick(); i++; end
    chk(0, "beats_before_reset", lg_data.size(), 3);
    axis_tready[0] = 1'b0;
    tick();
    chk(0, "full_pix_ready", pix_ready0, 0);
    chk(0, "full_tvalid", tvalid0, 1);
    arst = 1'b1;
    tick();
    chk(0, "midrst_tvalid", tvalid0, 0);
    chk(0, "midrst_busy", busy0, 0);
    chk(0, "midrst_pix_ready", pix_ready0, 0);
    chk(0, "midrst_tdata", tdata0, 0);
    arst = 1'b0; axis_tready[0] = 1'b1;
    restart_src(100); clear_logs();
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    run_frames(1, 0);
    check_frame(8, 100);

    // Back-to-back frames, second start in the cycle after done
    clear_logs(); restart_src(1);
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    run_frames(1, 0);
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    run_frames(2, 0);
    pix_valid[0] = 1'b0;
    check_frame(16, 1);

    // Randomized traffic on both instances
    rnd_data = 1'b1;
    i = 0;
    while (frames[1] < 1000 && i < 60000) begin
      for (int k = 0; k < 2; k++) begin
        pix_valid[k]   = ($urandom_range(0, 3) != 0);
        axis_tready[k] = ($urandom_range(0, 2) != 0);
        start[k]       = ($urandom_range(0, 3) == 0);
      end
      tick();
      i++;
    end
    chk(1, "random_frames", frames[1], 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
